amci_arbiter: RTL



---
 rtl/amci_arbiter_if.sv | 28 ++
 rtl/amci_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/amci_arbiter_if.sv
// amci_arbiter_if: one AMCI request/response port (write and read channels).
// The master modport is the requesting side, the slave modport the responding side.
interface amci_arbiter_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0] waddr;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic [2:0]                wsize;
    logic                      write;
    logic [1:0]                wresp;
    logic                      widle;
    logic [AXI_ADDR_WIDTH-1:0] raddr;
    logic [2:0]                rsize;
    logic                      read;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      ridle;

    modport master (
        output waddr, wdata, wsize, write, raddr, rsize, read,
        input  wresp, widle, rdata, rresp, ridle
    );
    modport slave (
        input  waddr, wdata, wsize, write, raddr, rsize, read,
        output wresp, widle, rdata, rresp, ridle
    );
endinterface

// File: rtl/amci_arbiter.sv
// amci_arbiter: shares one AMCI master port between two clients.
// Write and read channels are arbitrated independently, round-robin by default.
// Define AMCI_ARB_FIXED_PRIORITY_EN for fixed priority (client 0 wins ties).
module amci_arbiter #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           resetn,
    amci_arbiter_if.slave  s0,
    amci_arbiter_if.slave  s1,
    amci_arbiter_if.master m
);
    localparam logic [1:0] ST_IDLE  = 2'd0;  // waiting for a pending client and an idle master
    localparam logic [1:0] ST_START = 2'd1;  // request pulsed, waiting for the master to go busy
    localparam logic [1:0] ST_BUSY  = 2'd2;  // waiting for the master to return idle

    // Client inputs gathered into arrays so both clients share one code path
    logic [1:0]                wr_req, rd_req;
    logic [AXI_ADDR_WIDTH-1:0] c_waddr [2];
    logic [AXI_DATA_WIDTH-1:0] c_wdata [2];
    logic [2:0]                c_wsize [2];
    logic [AXI_ADDR_WIDTH-1:0] c_raddr [2];
    logic [2:0]                c_rsize [2];

    assign wr_req     = {s1.write, s0.write};
    assign rd_req     = {s1.read, s0.read};
    assign c_waddr[0] = s0.waddr;
    assign c_waddr[1] = s1.waddr;
    assign c_wdata[0] = s0.wdata;
    assign c_wdata[1] = s1.wdata;
    assign c_wsize[0] = s0.wsize;
    assign c_wsize[1] = s1.wsize;
    assign c_raddr[0] = s0.raddr;
    assign c_raddr[1] = s1.raddr;
    assign c_rsize[0] = s0.rsize;
    assign c_rsize[1] = s1.rsize;

    // Write channel state
    logic [AXI_ADDR_WIDTH-1:0] w_addr_q [2];
    logic [AXI_DATA_WIDTH-1:0] w_data_q [2];
    logic [2:0]                w_size_q [2];
    logic [1:0]                w_resp [2];
    logic [1:0]                w_pend, w_idle, w_state;
    logic                      w_win, w_sel, w_done;
    logic [AXI_ADDR_WIDTH-1:0] mw_addr;
    logic [AXI_DATA_WIDTH-1:0] mw_data;
    logic [2:0]                mw_size;
    logic                      mw_write;

    // Read channel state
    logic [AXI_ADDR_WIDTH-1:0] r_addr_q [2];
    logic [2:0]                r_size_q [2];
    logic [AXI_DATA_WIDTH-1:0] r_data [2];
    logic [1:0]                r_resp [2];
    logic [1:0]                r_pend, r_idle, r_state;
    logic                      r_win, r_sel, r_done;
    logic [AXI_ADDR_WIDTH-1:0] mr_addr;
    logic [2:0]                mr_size;
    logic                      mr_read;

    assign w_done = (w_state == ST_BUSY) && m.widle;
    assign r_done = (r_state == ST_BUSY) && m.ridle;

`ifdef AMCI_ARB_FIXED_PRIORITY_EN
    // Client 0 wins whenever it is pending
    assign w_sel = ~w_pend[0];
    assign r_sel = ~r_pend[0];
`else
    logic w_ptr, r_ptr;
    assign w_sel = (&w_pend) ? w_ptr : w_pend[1];
    assign r_sel = (&r_pend) ? r_ptr : r_pend[1];

    // Preference moves away from each client as its transaction completes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_ptr <= 1'b0;
            r_ptr <= 1'b0;
        end else begin
            if (w_done) w_ptr <= ~w_win;
            if (r_done) r_ptr <= ~r_win;
        end
    end
`endif

    // Latch request parameters from a client whose channel is idle
    // NOTE: holding registers carry no reset; they are read only after a capture has set the matching pending flag.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (wr_req[n] && w_idle[n]) begin
                w_addr_q[n] <= c_waddr[n];
                w_data_q[n] <= c_wdata[n];
                w_size_q[n] <= c_wsize[n];
            end
            if (rd_req[n] && r_idle[n]) begin
                r_addr_q[n] <= c_raddr[n];
                r_size_q[n] <= c_rsize[n];
            end
        end
    end

    // Write channel: capture flags, issue FSM and completion return
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state  <= ST_IDLE;
            w_pend   <= '0;
            w_idle   <= '1;
            w_resp   <= '{default: '0};
            w_win    <= 1'b0;
            mw_addr  <= '0;
            mw_data  <= '0;
            mw_size  <= '0;
            mw_write <= 1'b0;
        end else begin
            // A capture needs idle=1 and a completion needs idle=0, so they never touch the same client
            for (int n = 0; n < 2; n++) begin
                if (wr_req[n] && w_idle[n]) begin
                    w_pend[n] <= 1'b1;
                    w_idle[n] <= 1'b0;
                end
            end
            case (w_state)
                ST_IDLE: if ((|w_pend) && m.widle) begin
                    w_win    <= w_sel;
                    mw_addr  <= w_addr_q[w_sel];
                    mw_data  <= w_data_q[w_sel];
                    mw_size  <= w_size_q[w_sel];
                    mw_write <= 1'b1;
                    w_state  <= ST_START;
                end
                ST_START: begin
                    mw_write <= 1'b0;
                    if (!m.widle) w_state <= ST_BUSY;
                end
                ST_BUSY: if (m.widle) begin
                    w_resp[w_win] <= m.wresp;
                    w_idle[w_win] <= 1'b1;
                    w_pend[w_win] <= 1'b0;
                    w_state       <= ST_IDLE;
                end
                default: w_state <= ST_IDLE;
            endcase
        end
    end

    // Read channel: same structure, returning data and response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
            r_idle  <= '1;
            r_resp  <= '{default: '0};
            r_data  <= '{default: '0};
            r_win   <= 1'b0;
            mr_addr <= '0;
            mr_size <= '0;
            mr_read <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (rd_req[n] && r_idle[n]) begin
                    r_pend[n] <= 1'b1;
                    r_idle[n] <= 1'b0;
                end
            end
            case (r_state)
                ST_IDLE: if ((|r_pend) && m.ridle) begin
                    r_win   <= r_sel;
                    mr_addr <= r_addr_q[r_sel];
                    mr_size <= r_size_q[r_sel];
                    mr_read <= 1'b1;
                    r_state <= ST_START;
                end
                ST_START: begin
                    mr_read <= 1'b0;
                    if (!m.ridle) r_state <= ST_BUSY;
                end
                ST_BUSY: if (m.ridle) begin
                    r_data[r_win] <= m.rdata;
                    r_resp[r_win] <= m.rresp;
                    r_idle[r_win] <= 1'b1;
                    r_pend[r_win] <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m.waddr  = mw_addr;
    assign m.wdata  = mw_data;
    assign m.wsize  = mw_size;
    assign m.write  = mw_write;
    assign m.raddr  = mr_addr;
    assign m.rsize  = mr_size;
    assign m.read   = mr_read;

    assign s0.wresp = w_resp[0];
    assign s0.widle = w_idle[0];
    assign s0.rdata = r_data[0];
    assign s0.rresp = r_resp[0];
    assign s0.ridle = r_idle[0];
    assign s1.wresp = w_resp[1];
    assign s1.widle = w_idle[1];
    assign s1.rdata = r_data[1];
    assign s1.rresp = r_resp[1];
    assign s1.ridle = r_idle[1];
endmodule
